// File: rtl/processor_mc.sv
// Multi-cycle processor: 4 cycles/instruction (FETCH/DECODE/EXECUTE/WRITEBACK) with sync-read imem.
// No backpressure: loads and start are honoured only in IDLE/HALT; while busy they are dropped.
module processor_mc #(
  parameter int DW   = 32,
  parameter int NREG = 8,
  parameter int AW   = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic          retire,
  output logic [AW-1:0] pc,
  output logic [31:0]   instr,
  output logic          flag_z,
  output logic          flag_s,
  input  logic [3:0]    dbg_sel,
  output logic [DW-1:0] dbg_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;
  localparam logic [3:0] REG_LIM   = 4'(NREG);

  logic [31:0]   imem [2**AW];
  logic [31:0]   imem_rdata;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          err_q, err_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_s_q, flag_s_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [DW-1:0] res_q, res_d;
  logic          take_q, take_d;
  // Sized to the full 4-bit register field; entries >= NREG are never written.
  logic [DW-1:0] regs_q [16];
  logic [DW-1:0] regs_d [16];

  logic          idle_like;
  logic [3:0]    d_icode, d_ifun, d_ra, d_rb;
  logic          d_legal;
  logic [3:0]    x_icode, x_ifun, x_ra, x_rb;
  logic [AW-1:0] pc_inc;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);

  // The read is captured on the edge that enters FETCH, alongside any same-cycle load,
  // so a start+load to address 0 fetches the old word.
  always_ff @(posedge clock) begin
    if (load_en && idle_like) imem[load_addr] <= load_data;
    if (state_d == S_FETCH)   imem_rdata <= imem[pc_d];
  end

  assign d_icode = imem_rdata[31:28];
  assign d_ifun  = imem_rdata[27:24];
  assign d_ra    = imem_rdata[23:20];
  assign d_rb    = imem_rdata[19:16];

  always_comb begin
    d_legal = 1'b0;
    case (d_icode)
      4'h0:    d_legal = (d_ifun <= 4'd1);
      4'h1:    d_legal = (d_ifun == 4'd0) && (d_ra == 4'hF) && (d_rb < REG_LIM);
      4'h2:    d_legal = (d_ifun <= 4'd3) && (d_ra < REG_LIM) && (d_rb < REG_LIM);
      4'h4:    d_legal = (d_ifun <= 4'd2);
      default: d_legal = 1'b0;
    endcase
  end

  assign x_icode = instr_q[31:28];
  assign x_ifun  = instr_q[27:24];
  assign x_ra    = instr_q[23:20];
  assign x_rb    = instr_q[19:16];
  assign pc_inc  = pc_q + AW'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    err_d    = err_q;
    flag_z_d = flag_z_q;
    flag_s_d = flag_s_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    take_d   = take_q;
    regs_d   = regs_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        instr_d = imem_rdata;
        opa_d   = regs_q[d_ra];
        opb_d   = regs_q[d_rb];
        if (d_legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_EXECUTE: begin
        state_d = S_WB;
        take_d  = 1'b0;
        res_d   = DW'(instr_q[15:0]);
        if (x_icode == 4'h2) begin
          case (x_ifun[1:0])
            2'd0:    res_d = opa_q + opb_q;
            2'd1:    res_d = opa_q - opb_q;
            2'd2:    res_d = opa_q & opb_q;
            default: res_d = opa_q ^ opb_q;
          endcase
          flag_z_d = (res_d == '0);
          flag_s_d = res_d[DW-1];
        end else if (x_icode == 4'h4) begin
          case (x_ifun)
            4'd0:    take_d = 1'b1;
            4'd1:    take_d = flag_z_q;
            default: take_d = !flag_z_q;
          endcase
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (x_icode)
          4'h0: if (x_ifun == 4'd1) begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          4'h1:    regs_d[x_rb] = res_q;
          4'h2:    regs_d[x_ra] = res_q;
          4'h4:    if (take_q) pc_d = AW'(instr_q[15:0]);
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      err_q    <= 1'b0;
      flag_z_q <= 1'b0;
      flag_s_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      take_q   <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      err_q    <= err_d;
      flag_z_q <= flag_z_d;
      flag_s_q <= flag_s_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      take_q   <= take_d;
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_EXECUTE) || (state_q == S_WB);
  assign halted   = (state_q == S_HALT);
  assign err      = err_q;
  assign retire   = (state_q == S_WB);
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign flag_z   = flag_z_q;
  assign flag_s   = flag_s_q;
  assign dbg_data = (dbg_sel < REG_LIM) ? regs_q[dbg_sel] : '0;

endmodule

// File: tb/tb_processor_mc.sv
// Directed bench for processor_mc: default instance plus an AW=2 instance for PC wrap.
module tb_processor_mc;
  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        load_en, start, busy, halted, err, retire, flag_z, flag_s;
  logic [8:0]  load_addr, pc;
  logic [31:0] load_data, instr, dbg_data;
  logic [3:0]  dbg_sel;

  logic        load_en2, start2, busy2, halted2, err2, retire2, flag_z2, flag_s2;
  logic [1:0]  load_addr2, pc2;
  logic [31:0] load_data2, instr2, dbg_data2;
  logic [3:0]  dbg_sel2;

  int checks = 0;
  int errors = 0;

  processor_mc #(.DW(32), .NREG(8), .AW(9)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .busy(busy), .halted(halted), .err(err),
    .retire(retire), .pc(pc), .instr(instr), .flag_z(flag_z), .flag_s(flag_s),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  processor_mc #(.DW(32), .NREG(8), .AW(2)) dut2 (
    .clock(clock), .reset(reset), .load_en(load_en2), .load_addr(load_addr2),
    .load_data(load_data2), .start(start2), .busy(busy2), .halted(halted2), .err(err2),
    .retire(retire2), .pc(pc2), .instr(instr2), .flag_z(flag_z2), .flag_s(flag_s2),
    .dbg_sel(dbg_sel2), .dbg_data(dbg_data2)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    load_en = 0; start = 0; load_en2 = 0; start2 = 0;
    reset = 0;
    tick();
    reset = 1;
    tick();
  endtask

  task automatic load(input logic [8:0] a, input logic [31:0] d);
    load_addr = a; load_data = d; load_en = 1;
    tick();
    load_en = 0;
  endtask

  task automatic load2(input logic [1:0] a, input logic [31:0] d);
    load_addr2 = a; load_data2 = d; load_en2 = 1;
    tick();
    load_en2 = 0;
  endtask

  task automatic run(output int cyc, output int nret);
    start = 1;
    tick();
    start = 0;
    cyc = 0; nret = 0;
    while (!halted && cyc < 400) begin
      tick();
      cyc++;
      if (retire) nret++;
    end
  endtask

  task automatic rd(input int i, output logic [31:0] v);
    dbg_sel = 4'(i);
    #1;
    v = dbg_data;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    do_reset();
    checks++;
    if ({busy, halted, err, retire, flag_z, flag_s} !== 6'b0) begin
      errors++; $display("FAIL reset_status: got %b expected 000000", {busy, halted, err, retire, flag_z, flag_s});
    end
    checks++;
    if (pc !== 9'd0 || instr !== 32'd0) begin
      errors++; $display("FAIL reset_pc_instr: got pc=%0d instr=%h expected 0/0", pc, instr);
    end
    for (int i = 0; i < 16; i++) begin
      rd(i, v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0", i, v); end
    end
  endtask

  task automatic test_irmov_all;
    int cyc, nret;
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 8; i++) load(9'(i), {8'h10, 4'hF, 4'(i), 16'h0080 + 16'(i)});
    load(9'd8, 32'h0100_0000);
    run(cyc, nret);
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      checks++;
      if (v !== 32'h80 + 32'(i)) begin errors++; $display("FAIL irmov_r%0d: got %h expected %h", i, v, 32'h80 + 32'(i)); end
    end
    rd(8, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL dbg_out_of_range: got %h expected 0", v); end
    checks++;
    if (nret !== 9) begin errors++; $display("FAIL irmov_retires: got %0d expected 9", nret); end
    checks++;
    if (cyc !== 36) begin errors++; $display("FAIL irmov_cycles: got %0d expected 36", cyc); end
    checks++;
    if (halted !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL irmov_halt: got h=%b e=%b b=%b expected 1 0 0", halted, err, busy);
    end
    checks++;
    if (pc !== 9'd8) begin errors++; $display("FAIL irmov_pc: got %0d expected 8", pc); end
  endtask

  task automatic test_jz;
    int cyc, nret;
    logic [31:0] v;
    do_reset();
    load(0, 32'h10F0_0005); load(1, 32'h10F1_0005); load(2, 32'h2101_0000);
    load(3, 32'h4100_0007); load(4, 32'h10F2_0001); load(5, 32'h0100_0000);
    load(6, 32'h10F2_0002); load(7, 32'h0100_0000);
    run(cyc, nret);
    rd(0, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL jz_r0: got %h expected 0", v); end
    rd(2, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL jz_r2: got %h expected 0", v); end
    checks++;
    if (flag_z !== 1'b1 || flag_s !== 1'b0) begin errors++; $display("FAIL jz_flags: got z=%b s=%b expected 1 0", flag_z, flag_s); end
    checks++;
    if (pc !== 9'd7 || halted !== 1'b1) begin errors++; $display("FAIL jz_pc: got pc=%0d h=%b expected 7 1", pc, halted); end
    checks++;
    if (nret !== 5) begin errors++; $display("FAIL jz_retires: got %0d expected 5", nret); end
  endtask

  task automatic test_flags;
    int cyc, nret;
    logic [31:0] v;
    do_reset();
    load(0, 32'h10F0_0000); load(1, 32'h10F1_0001); load(2, 32'h2101_0000); load(3, 32'h0100_0000);
    run(cyc, nret);
    rd(0, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_r0: got %h expected ffffffff", v); end
    checks++;
    if (flag_s !== 1'b1 || flag_z !== 1'b0) begin errors++; $display("FAIL sub_flags: got s=%b z=%b expected 1 0", flag_s, flag_z); end
    load(3, 32'h2300_0000); load(4, 32'h0100_0000);
    run(cyc, nret);
    rd(0, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL xor_r0: got %h expected 0", v); end
    checks++;
    if (flag_z !== 1'b1 || flag_s !== 1'b0 || pc !== 9'd4) begin
      errors++; $display("FAIL xor_flags: got z=%b s=%b pc=%0d expected 1 0 4", flag_z, flag_s, pc);
    end
  endtask

  task automatic test_add_and_jnz;
    int cyc, nret;
    logic [31:0] v;
    do_reset();
    load(0, 32'h10F3_00F0); load(1, 32'h10F4_0F3C); load(2, 32'h2034_0000);
    load(3, 32'h2243_0000); load(4, 32'h4200_0007); load(5, 32'h10F5_0001);
    load(6, 32'h0100_0000); load(7, 32'h0100_0000);
    run(cyc, nret);
    rd(3, v);
    checks++;
    if (v !== 32'h0000_102C) begin errors++; $display("FAIL add_r3: got %h expected 0000102c", v); end
    rd(4, v);
    checks++;
    if (v !== 32'h0000_002C) begin errors++; $display("FAIL and_r4: got %h expected 0000002c", v); end
    rd(5, v);
    checks++;
    if (v !== 32'd0 || pc !== 9'd7) begin errors++; $display("FAIL jnz_taken: got r5=%h pc=%0d expected 0 7", v, pc); end
  endtask

  task automatic test_illegal;
    int cyc, nret;
    logic [31:0] v;
    logic [31:0] bad [5];
    bad[0] = 32'h5000_0000; bad[1] = 32'h10E0_0001; bad[2] = 32'h2080_0000;
    bad[3] = 32'h4300_0000; bad[4] = 32'h10F8_0003;
    do_reset();
    load(0, 32'h10F0_0011); load(1, 32'h0000_0000); load(3, 32'h0100_0000);
    for (int k = 0; k < 5; k++) begin
      load(2, bad[k]);
      start = 1;
      tick();
      start = 0;
      checks++;
      if (err !== 1'b0 || busy !== 1'b1 || pc !== 9'd0) begin
        errors++; $display("FAIL ill_restart%0d: got e=%b b=%b pc=%0d expected 0 1 0", k, err, busy, pc);
      end
      cyc = 0; nret = 0;
      while (!halted && cyc < 400) begin tick(); cyc++; if (retire) nret++; end
      checks++;
      if (halted !== 1'b1 || err !== 1'b1 || pc !== 9'd2) begin
        errors++; $display("FAIL ill_halt%0d: got h=%b e=%b pc=%0d expected 1 1 2", k, halted, err, pc);
      end
      checks++;
      if (nret !== 2 || cyc !== 10) begin
        errors++; $display("FAIL ill_timing%0d: got ret=%0d cyc=%0d expected 2 10", k, nret, cyc);
      end
      rd(0, v);
      checks++;
      if (v !== 32'h11) begin errors++; $display("FAIL ill_regs%0d: got r0=%h expected 11", k, v); end
    end
  endtask

  task automatic test_load_busy;
    int cyc, nret;
    logic [31:0] v;
    do_reset();
    load(0, 32'h10F0_0007); load(1, 32'h0100_0000);
    start = 1;
    tick();
    start = 0;
    tick();
    load(0, 32'h0100_0000);
    cyc = 0;
    while (!halted && cyc < 400) begin tick(); cyc++; end
    rd(0, v);
    checks++;
    if (v !== 32'd7 || pc !== 9'd1) begin errors++; $display("FAIL busy_load_run1: got r0=%h pc=%0d expected 7 1", v, pc); end
    do_reset();
    run(cyc, nret);
    rd(0, v);
    checks++;
    if (v !== 32'd7 || nret !== 2) begin errors++; $display("FAIL busy_load_run2: got r0=%h ret=%0d expected 7 2", v, nret); end
    // start and load coincide in IDLE: the fetch sees the old word at address 0
    do_reset();
    load_addr = 0; load_data = 32'h10F0_0009; load_en = 1; start = 1;
    tick();
    load_en = 0; start = 0;
    cyc = 0;
    while (!halted && cyc < 400) begin tick(); cyc++; end
    rd(0, v);
    checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL coincide_old: got r0=%h expected 7", v); end
    run(cyc, nret);
    rd(0, v);
    checks++;
    if (v !== 32'd9) begin errors++; $display("FAIL coincide_new: got r0=%h expected 9", v); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    do_reset();
    load(0, 32'h10F1_0055); load(1, 32'h0100_0000);
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    reset = 0;
    #1;
    rd(1, v);
    checks++;
    if (v !== 32'd0 || busy !== 1'b0 || pc !== 9'd0) begin
      errors++; $display("FAIL reset_mid: got r1=%h busy=%b pc=%0d expected 0 0 0", v, busy, pc);
    end
    tick();
    reset = 1;
    tick();
  endtask

  task automatic test_pc_wrap;
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) load2(2'(i), 32'h0000_0000);
    start2 = 1;
    tick();
    start2 = 0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      start2 = (i == 9);
      tick();
      if (retire2) begin
        checks++;
        if (pc2 !== 2'(k)) begin errors++; $display("FAIL wrap_pc%0d: got %0d expected %0d", k, pc2, k % 4); end
        k++;
      end
    end
    start2 = 0;
    checks++;
    if (k !== 5) begin errors++; $display("FAIL wrap_retires: got %0d expected 5", k); end
    reset = 0;
    #1;
    checks++;
    if (pc2 !== 2'd0 || busy2 !== 1'b0) begin errors++; $display("FAIL wrap_reset: got pc=%0d busy=%b expected 0 0", pc2, busy2); end
    for (int i = 0; i < 8; i++) begin
      dbg_sel2 = 4'(i);
      #1;
      checks++;
      if (dbg_data2 !== 32'd0) begin errors++; $display("FAIL wrap_reg%0d: got %h expected 0", i, dbg_data2); end
    end
    tick();
    reset = 1;
    tick();
  endtask

  initial begin
    reset = 1; load_en = 0; start = 0; load_addr = 0; load_data = 0; dbg_sel = 0;
    load_en2 = 0; start2 = 0; load_addr2 = 0; load_data2 = 0; dbg_sel2 = 0;
    #2;
    test_reset();
    test_irmov_all();
    test_jz();
    test_flags();
    test_add_and_jnz();
    test_illegal();
    test_load_busy();
    test_reset_mid();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/processor_mc.md
Name: processor_mc

Overview:
- Parametrised multi-cycle successor to processor Z.
- Holds instruction memory, register file and ALU. Instruction memory is loaded through a write port while the core is idle. Programs run from PC=0 through an explicit FSM (FETCH/DECODE/EXECUTE/WRITEBACK).
- Adds over processor Z: configurable data width, register count and memory depth; jumps and conditional jumps; flags; halt and error reporting; debug register read port.

Parameters:
DW, 32, data/register width in bits; must be >= 16.
NREG, 8, number of architectural registers, 2..15; index 15 (0xF) is reserved as "none".
AW, 9, instruction memory address width; depth = 2^AW words of 32 bits.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
load_en  in  1  write load_data to imem[load_addr]; honoured only in IDLE or HALT
load_addr  in  AW  load address
load_data  in  32  instruction word to store
start  in  1  1-cycle pulse; in IDLE or HALT, clears PC to 0 and begins execution
busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
halted  out  1  high in HALT
err  out  1  high in HALT if entered through an illegal instruction
retire  out  1  1-cycle pulse in the WRITEBACK cycle of each completed instruction
pc  out  AW  current PC
instr  out  32  latched instruction word
flag_z  out  1  zero flag from the last ALU op
flag_s  out  1  sign flag (MSB) from the last ALU op
dbg_sel  in  4  debug register select
dbg_data  out  DW  combinational read of reg[dbg_sel]; 0 if dbg_sel >= NREG

Behaviour:
- Reset (async, reset=0):
  - State=IDLE; pc=0; instr=0; all registers 0; flags 0; err=0; busy=0; halted=0; retire=0.
  - Instruction memory contents are not reset.
- Instruction fields: icode=[31:28], ifun=[27:24], rA=[23:20], rB=[19:16], valC=[15:0], zero-extended to DW.
- Instruction memory: synchronous read, 1-cycle latency. A write and a read to the same address in the same cycle returns the old data.
- FSM, 4 cycles per instruction:
  - IDLE: start -> FETCH with pc=0; load_en writes memory.
  - FETCH: issue imem read at pc -> DECODE.
  - DECODE: latch instr and read rA/rB operands. An illegal encoding goes -> HALT with err=1 and no state change; otherwise -> EXECUTE.
  - EXECUTE: ALU computes; jump condition evaluated -> WRITEBACK.
  - WRITEBACK: register write; pc update; retire=1.
    - HALT instruction -> HALT.
    - Otherwise -> FETCH.
  - HALT: start -> FETCH with pc=0 and err cleared; load_en writes memory.
- ISA:
  - 0x00 NOP: pc+1.
  - 0x01 HALT: retires, then enters HALT; pc is not incremented.
  - 0x10 IRMOV: reg[rB] <= valC; rA must be 0xF.
  - 0x20..0x23 OP: reg[rA] <= reg[rA] op reg[rB].
    - ifun 0=add, 1=sub (rA-rB), 2=and, 3=xor.
    - Result modulo 2^DW; flag_z=(result==0); flag_s=result[DW-1].
    - Flags update only on OP.
  - 0x40 JMP: pc <= valC[AW-1:0].
  - 0x41 JZ: jump if flag_z, else pc+1.
  - 0x42 JNZ: jump if !flag_z, else pc+1.
- Illegal encodings:
  - Any other icode/ifun.
  - A register field that is used and is >= NREG.
  - IRMOV with rA != 0xF.
- PC arithmetic: pc+1 wraps from 2^AW-1 to 0 with no error.
- Priority and ignored inputs:
  - load_en while busy is ignored and leaves memory unchanged.
  - start while busy is ignored.
  - If start and load_en coincide in IDLE, both are performed; the fetch at pc=0 sees the old word if load_addr=0.
- Reset mid-instruction: aborts immediately to IDLE; a partially executed instruction leaves no register write.
- Register writes happen only in WRITEBACK. dbg_data reflects a write in the cycle after WRITEBACK.

Test Plan:
- Load IRMOV r0..r7 with 0x0080..0x0087, then HALT; start -> r0..r7 = 0x80..0x87. There are 9 retire pulses, halted=1, err=0, pc=8, and total time from start to halted is 36 cycles.
- Run IRMOV r0=5, IRMOV r1=5, SUB r0,r1, JZ 7, IRMOV r2=1, HALT at 5, HALT at 7 -> r0=0, flag_z=1, r2=0, pc=7 at halt.
- Run IRMOV r0=0, IRMOV r1=1, SUB r0,r1 -> r0=0xFFFFFFFF, flag_s=1, flag_z=0. Then XOR r0,r0 -> r0=0, flag_z=1.
- Place the word 0x50000000 at address 2 -> halted=1 and err=1 at pc=2, registers unchanged. Pulse start -> err clears and execution restarts at pc=0.
- With AW=2, fill memory with NOPs and assert reset after 20 cycles -> pc sequence 0,1,2,3,0,1… Reset gives pc=0, busy=0, and all registers 0.
- While busy, pulse load_en to address 0 with 0x01000000 -> imem[0] unchanged. A later run from start still executes the original word.
